// File: rtl/game_sequencer_if.sv
// Keypad-side and renderer-side signals of the game sequencer, bundled so the
// sequencer, the keypad decoder and control_game share one port list.
// The keypad side is the master (drives iKey/iKeyVld); the sequencer is the slave.
interface game_sequencer_if;
    logic [3:0] iKey;
    logic       iKeyVld;
    logic [3:0] oNum1;
    logic [3:0] oNum2;
    logic [3:0] oNum3;
    logic       oNumRdy;
    logic [1:0] oHitA;
    logic [1:0] oHitB;
    logic [3:0] oTries;
    logic       oWin;
    logic       oLose;
    logic [1:0] oEntryCnt;

    modport master (
        output iKey, iKeyVld,
        input  oNum1, oNum2, oNum3, oNumRdy, oHitA, oHitB,
        input  oTries, oWin, oLose, oEntryCnt
    );

    modport slave (
        input  iKey, iKeyVld,
        output oNum1, oNum2, oNum3, oNumRdy, oHitA, oHitB,
        output oTries, oWin, oLose, oEntryCnt
    );
endinterface

// File: rtl/game_sequencer.sv
// Round sequencer for the three-digit bulls-and-cows game.
// Generates a secret with distinct digits from a free-running BCD counter,
// assembles keypad digits into a guess, scores it and publishes the result
// with a one-cycle ready strobe. Tracks tries and the win/lose outcome.
// Optional feature: define GAME_REVEAL_EN to add a REVEAL cycle that shows
// the secret after the losing guess.
module game_sequencer #(
    parameter int MAX_TRIES = 8
) (
    input  logic            clk,
    input  logic            reset,
    game_sequencer_if.slave bus
);

    typedef enum logic [2:0] {IDLE, GEN, ENTRY, SCORE, PUB, REVEAL, WIN, LOSE} state_t;

    localparam logic [3:0] KEY_CLR     = 4'hA;
    localparam logic [3:0] KEY_ENT     = 4'hB;
    localparam logic [3:0] TRIES_LIMIT = 4'(MAX_TRIES);

    state_t      state_q, state_d;
    logic [11:0] counter_q, counter_d;
    logic [11:0] cand_q, cand_d;
    logic [11:0] secret_q, secret_d;
    logic [11:0] guess_q, guess_d;
    logic [11:0] num_q, num_d;
    logic [1:0]  entry_q, entry_d;
    logic [1:0]  hit_a_q, hit_a_d;
    logic [1:0]  hit_b_q, hit_b_d;
    logic [1:0]  score_a, score_b;
    logic [3:0]  tries_q, tries_d;
    logic        rdy_q, rdy_d;
    logic        win_q, lose_q;

    // Three-digit BCD increment, 999 wraps to 000.
    function automatic logic [11:0] bcd_inc(input logic [11:0] v);
        logic [3:0] d2, d1, d0;
        {d2, d1, d0} = v;
        if (d0 == 4'd9) begin
            d0 = 4'd0;
            if (d1 == 4'd9) begin
                d1 = 4'd0;
                d2 = (d2 == 4'd9) ? 4'd0 : d2 + 4'd1;
            end else begin
                d1 = d1 + 4'd1;
            end
        end else begin
            d0 = d0 + 4'd1;
        end
        return {d2, d1, d0};
    endfunction

    function automatic logic distinct(input logic [11:0] v);
        return (v[11:8] != v[7:4]) && (v[7:4] != v[3:0]) && (v[11:8] != v[3:0]);
    endfunction

    // Score the current guess against the secret: same position counts as A,
    // different position counts as B. Both are distinct-digit, so B <= 3.
    always_comb begin
        score_a = '0;
        score_b = '0;
        for (int i = 0; i < 3; i++) begin
            for (int j = 0; j < 3; j++) begin
                if (guess_q[4*i +: 4] == secret_q[4*j +: 4]) begin
                    if (i == j) score_a = score_a + 2'd1;
                    else        score_b = score_b + 2'd1;
                end
            end
        end
    end

    // Next-state and next-output logic for the round FSM.
    always_comb begin
        // NOTE: every variable gets a default first so no path can infer a latch.
        state_d   = state_q;
        counter_d = (state_q == IDLE || state_q == GEN) ? bcd_inc(counter_q) : counter_q;
        cand_d    = cand_q;
        secret_d  = secret_q;
        guess_d   = guess_q;
        num_d     = num_q;
        entry_d   = entry_q;
        hit_a_d   = hit_a_q;
        hit_b_d   = hit_b_q;
        tries_d   = tries_q;
        rdy_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.iKeyVld) begin
                    cand_d  = counter_q;
                    state_d = GEN;
                end
            end
            GEN: begin
                if (distinct(cand_q)) begin
                    secret_d = cand_q;
                    tries_d  = '0;
                    entry_d  = '0;
                    state_d  = ENTRY;
                end else begin
                    cand_d = bcd_inc(cand_q);
                end
            end
            ENTRY: begin
                if (bus.iKeyVld) begin
                    if (bus.iKey <= 4'd9) begin
                        if (entry_q != 2'd3) begin
                            case (entry_q)
                                2'd0:    guess_d[11:8] = bus.iKey;
                                2'd1:    guess_d[7:4]  = bus.iKey;
                                default: guess_d[3:0]  = bus.iKey;
                            endcase
                            entry_d = entry_q + 2'd1;
                        end
                    end else if (bus.iKey == KEY_CLR) begin
                        entry_d = '0;
                    end else if (bus.iKey == KEY_ENT && entry_q == 2'd3) begin
                        if (distinct(guess_q)) begin
                            // Tries lead the ready strobe by one cycle.
                            tries_d = (tries_q == 4'hF) ? tries_q : tries_q + 4'd1;
                            state_d = SCORE;
                        end else begin
                            entry_d = '0;
                        end
                    end
                end
            end
            SCORE: begin
                num_d   = guess_q;
                hit_a_d = score_a;
                hit_b_d = score_b;
                rdy_d   = 1'b1;
                entry_d = '0;
                state_d = PUB;
            end
            PUB: begin
                if (hit_a_q == 2'd3) begin
                    state_d = WIN;
                end else if (tries_q == TRIES_LIMIT) begin
`ifdef GAME_REVEAL_EN
                    num_d   = secret_q;
                    hit_a_d = '0;
                    hit_b_d = '0;
                    rdy_d   = 1'b1;
                    state_d = REVEAL;
`else
                    state_d = LOSE;
`endif
                end else begin
                    state_d = ENTRY;
                end
            end
            REVEAL: begin
                state_d = LOSE;
            end
            WIN, LOSE: begin
                if (bus.iKeyVld) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; every output comes straight from a flop.
    always_ff @(posedge clk or posedge reset) begin
        // NOTE: all state, including the secret and guess, is reset so nothing
        // stale survives a mid-game reset.
        if (reset) begin
            state_q   <= IDLE;
            counter_q <= '0;
            cand_q    <= '0;
            secret_q  <= '0;
            guess_q   <= '0;
            num_q     <= '0;
            entry_q   <= '0;
            hit_a_q   <= '0;
            hit_b_q   <= '0;
            tries_q   <= '0;
            rdy_q     <= 1'b0;
            win_q     <= 1'b0;
            lose_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            counter_q <= counter_d;
            cand_q    <= cand_d;
            secret_q  <= secret_d;
            guess_q   <= guess_d;
            num_q     <= num_d;
            entry_q   <= entry_d;
            hit_a_q   <= hit_a_d;
            hit_b_q   <= hit_b_d;
            tries_q   <= tries_d;
            rdy_q     <= rdy_d;
            win_q     <= (state_d == WIN);
            lose_q    <= (state_d == LOSE);
        end
    end

    assign bus.oNum1     = num_q[11:8];
    assign bus.oNum2     = num_q[7:4];
    assign bus.oNum3     = num_q[3:0];
    assign bus.oNumRdy   = rdy_q;
    assign bus.oHitA     = hit_a_q;
    assign bus.oHitB     = hit_b_q;
    assign bus.oTries    = tries_q;
    assign bus.oWin      = win_q;
    assign bus.oLose     = lose_q;
    assign bus.oEntryCnt = entry_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Directed testbench for game_sequencer. Inputs change on the falling edge,
// outputs are sampled on the falling edge.
module tb_game_sequencer;

    logic clk = 1'b0;
    logic reset;

    game_sequencer_if bus ();

    game_sequencer #(.MAX_TRIES(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One-cycle key strobe; call at a falling edge, returns at the next one.
    task automatic press(input logic [3:0] k);
        bus.iKey    = k;
        bus.iKeyVld = 1'b1;
        @(negedge clk);
        bus.iKeyVld = 1'b0;
        bus.iKey    = 4'h0;
    endtask

    // Three digits followed by enter; returns in the SCORE cycle if accepted.
    task automatic guess(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        press(a);
        press(b);
        press(c);
        press(4'hB);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wake so the counter value k is captured; called right after a release at a falling edge.
    task automatic wake_at(input int k);
        repeat (k) @(posedge clk);
        @(negedge clk);
        press(4'hC);
        repeat (3) @(negedge clk);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_num"},   {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h000);
        check({tag, "_rdy"},   12'(bus.oNumRdy), 12'h0);
        check({tag, "_hits"},  12'({bus.oHitA, bus.oHitB}), 12'h0);
        check({tag, "_tries"}, 12'(bus.oTries), 12'h0);
        check({tag, "_wl"},    12'({bus.oWin, bus.oLose}), 12'h0);
        check({tag, "_entry"}, 12'(bus.oEntryCnt), 12'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset       = 1'b1;
        bus.iKey    = 4'h0;
        bus.iKeyVld = 1'b0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        // Wake captures 000; GEN runs 13 cycles up to 012.
        press(4'hC);
        repeat (12) @(negedge clk);
        press(4'h0);
        check("gen_key_dropped", 12'(bus.oEntryCnt), 12'd0);
        press(4'h0);
        check("gen_done_entry", 12'(bus.oEntryCnt), 12'd1);
        press(4'h1);
        press(4'h2);
        press(4'hB);
        check("s012_score_rdy", 12'(bus.oNumRdy), 12'd0);
        check("s012_tries", 12'(bus.oTries), 12'd1);
        @(negedge clk);
        check("s012_rdy", 12'(bus.oNumRdy), 12'd1);
        check("s012_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h012);
        check("s012_hits", 12'({bus.oHitA, bus.oHitB}), 12'b1100);
        @(negedge clk);
        check("s012_rdy_end", 12'(bus.oNumRdy), 12'd0);
        check("s012_win", 12'(bus.oWin), 12'd1);

        // Secret 123: partial matches, then misses.
        do_reset();
        wake_at(123);
        guess(4'h3, 4'h2, 4'h1);
        @(negedge clk);
        check("g321_rdy", 12'(bus.oNumRdy), 12'd1);
        check("g321_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h321);
        check("g321_a", 12'(bus.oHitA), 12'd1);
        check("g321_b", 12'(bus.oHitB), 12'd2);
        check("g321_tries", 12'(bus.oTries), 12'd1);
        @(negedge clk);
        check("g321_rdy_end", 12'(bus.oNumRdy), 12'd0);
        check("g321_wl", 12'({bus.oWin, bus.oLose}), 12'd0);
        guess(4'h4, 4'h5, 4'h6);
        @(negedge clk);
        check("g456_hits", 12'({bus.oHitA, bus.oHitB}), 12'd0);
        check("g456_tries", 12'(bus.oTries), 12'd2);
        check("g456_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h456);
        @(negedge clk);

        // Duplicate guess rejected, short enter ignored, fourth digit ignored, clear.
        guess(4'h1, 4'h1, 4'h2);
        check("dup_entry", 12'(bus.oEntryCnt), 12'd0);
        check("dup_tries", 12'(bus.oTries), 12'd2);
        @(negedge clk);
        check("dup_no_rdy1", 12'(bus.oNumRdy), 12'd0);
        @(negedge clk);
        check("dup_no_rdy2", 12'(bus.oNumRdy), 12'd0);
        press(4'h4);
        press(4'h5);
        press(4'hB);
        check("short_enter", 12'(bus.oEntryCnt), 12'd2);
        press(4'h6);
        check("third_digit", 12'(bus.oEntryCnt), 12'd3);
        press(4'h7);
        check("fourth_digit", 12'(bus.oEntryCnt), 12'd3);
        press(4'hA);
        check("clear", 12'(bus.oEntryCnt), 12'd0);
        guess(4'h1, 4'h2, 4'h3);
        @(negedge clk);
        check("g123_hits", 12'({bus.oHitA, bus.oHitB}), 12'b1100);
        check("g123_tries", 12'(bus.oTries), 12'd3);
        @(negedge clk);
        check("g123_win", 12'(bus.oWin), 12'd1);

        // Reset asserted during SCORE.
        do_reset();
        wake_at(123);
        guess(4'h4, 4'h5, 4'h6);
        repeat (2) @(negedge clk);
        guess(4'h3, 4'h2, 4'h1);
        check("pre_rst_tries", 12'(bus.oTries), 12'd2);
        reset = 1'b1;
        #1;
        check_all_zero("rst_score");
        @(negedge clk);
        check("rst_no_rdy", 12'(bus.oNumRdy), 12'd0);
        reset = 1'b0;
        wake_at(123);
        guess(4'h1, 4'h2, 4'h3);
        @(negedge clk);
        check("post_rst_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h123);
        check("post_rst_hits", 12'({bus.oHitA, bus.oHitB}), 12'b1100);
        check("post_rst_tries", 12'(bus.oTries), 12'd1);
        @(negedge clk);
        check("post_rst_win", 12'(bus.oWin), 12'd1);

        // Eight misses lose the game.
        do_reset();
        wake_at(123);
        for (int i = 0; i < 7; i++) begin
            guess(4'h4, 4'h5, 4'h6);
            repeat (2) @(negedge clk);
        end
        check("lose_tries7", 12'(bus.oTries), 12'd7);
        guess(4'h4, 4'h5, 4'h6);
        check("lose_tries8", 12'(bus.oTries), 12'd8);
        @(negedge clk);
        check("lose_last_rdy", 12'(bus.oNumRdy), 12'd1);
        check("lose_last_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h456);
        @(negedge clk);
`ifdef GAME_REVEAL_EN
        check("reveal_rdy", 12'(bus.oNumRdy), 12'd1);
        check("reveal_num", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h123);
        check("reveal_hits", 12'({bus.oHitA, bus.oHitB}), 12'd0);
        check("reveal_lose", 12'(bus.oLose), 12'd0);
        @(negedge clk);
`endif
        check("lose_level", 12'(bus.oLose), 12'd1);
        check("lose_rdy_end", 12'(bus.oNumRdy), 12'd0);
`ifndef GAME_REVEAL_EN
        check("lose_num_hold", {bus.oNum1, bus.oNum2, bus.oNum3}, 12'h456);
`endif
        press(4'hC);
        check("lose_exit", 12'(bus.oLose), 12'd0);
        check("idle_tries_hold", 12'(bus.oTries), 12'd8);
        press(4'hC);
        repeat (30) @(negedge clk);
        check("new_game_tries", 12'(bus.oTries), 12'd0);
        check("new_game_entry", 12'(bus.oEntryCnt), 12'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
